// File: rtl/store_trace_pkg.sv
// Shared types and constants for the store trace buffer.
// trace_entry_t is the default-width view of one captured store.
package store_trace_pkg;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADR_W  = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_SEQ_W  = 16;

  localparam logic [7:0] DROP_CNT_MAX = 8'd255;

  typedef struct packed {
    logic [DEF_SEQ_W-1:0]  seq;
    logic [DEF_ADR_W-1:0]  adr;
    logic [DEF_DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage, natural-wrap pointers and an
// occupancy counter that alone decides full/empty.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 80
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic [PW:0]      count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (PW+1)'(DEPTH));
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push;
  assign count     = count_q;
  assign rdata     = mem_q[rd_ptr_q];

  // Occupancy next state
  always_comb begin
    count_d = count_q;
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + (PW+1)'(1);
    end else if (do_pop_s && !do_push_s) begin
      count_d = count_q - (PW+1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Storage is cleared too so the head is never X once reset has been seen
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/store_trace_buffer.sv
// Captures data-memory stores with a sequence number into a FIFO drained over
// valid/ready; drops on overflow. Optional address filter: STORE_TRACE_FILTER_EN.
module store_trace_buffer
  import store_trace_pkg::*;
#(
  parameter int               DEPTH     = DEF_DEPTH,
  parameter int               ADR_W     = DEF_ADR_W,
  parameter int               DATA_W    = DEF_DATA_W,
  parameter int               SEQ_W     = DEF_SEQ_W,
  parameter logic [ADR_W-1:0] FILT_BASE = '0,
  parameter logic [ADR_W-1:0] FILT_MASK = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_write,
  input  logic [ADR_W-1:0]       data_adr,
  input  logic [DATA_W-1:0]      write_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADR_W-1:0]       out_adr,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEQ_W-1:0]       out_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [SEQ_W-1:0] seq_q;
  logic [SEQ_W-1:0] seq_d;
  logic             overflow_q;
  logic             overflow_d;
  logic [7:0]       drop_cnt_q;
  logic [7:0]       drop_cnt_d;
  logic             filt_pass_s;
  logic             qualify_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic             full_s;
  logic             empty_s;
  entry_t           wr_entry_s;
  entry_t           head_s;

`ifdef STORE_TRACE_FILTER_EN
  assign filt_pass_s = ((data_adr & FILT_MASK) == FILT_BASE);
`else
  logic unused_filt_s;
  assign filt_pass_s   = 1'b1;
  assign unused_filt_s = ^{FILT_BASE, FILT_MASK};
`endif

  // A full FIFO still accepts a store when the head leaves on the same edge
  assign qualify_s = mem_write & filt_pass_s;
  assign pop_s     = ~empty_s & out_ready;
  assign push_s    = qualify_s & (~full_s | pop_s);
  assign drop_s    = qualify_s & full_s & ~pop_s;

  assign wr_entry_s = '{seq: seq_q, adr: data_adr, data: write_data};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wr_entry_s),
    .rdata (head_s),
    .count (count),
    .full  (full_s),
    .empty (empty_s)
  );

  assign out_valid = ~empty_s;
  assign out_adr   = head_s.adr;
  assign out_data  = head_s.data;
  assign out_seq   = head_s.seq;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  // Sequence advances on every qualifying store, kept or dropped
  always_comb begin
    seq_d      = seq_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (qualify_s) begin
      seq_d = seq_q + SEQ_W'(1);
    end else begin
      seq_d = seq_q;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != DROP_CNT_MAX) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Tag and drop-status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_store_trace_buffer.sv
// Directed, table-driven bench for store_trace_buffer plus hand-written
// multi-cycle sequences (push/pop at full, reset, sequence wrap, saturation).
module tb_store_trace_buffer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, default parameters
  logic        reset, mem_write, out_ready;
  logic [31:0] data_adr, write_data;
  logic        out_valid, overflow;
  logic [31:0] out_adr, out_data;
  logic [15:0] out_seq;
  logic [3:0]  count;
  logic [7:0]  drop_cnt;

  store_trace_buffer u_dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_adr(out_adr), .out_data(out_data), .out_seq(out_seq), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  // Narrow sequence number instance
  logic        w_reset, w_wr, w_rdy;
  logic [31:0] w_adr, w_data;
  logic        w_valid, w_overflow;
  logic [31:0] w_out_adr, w_out_data;
  logic [3:0]  w_out_seq;
  logic [3:0]  w_count;
  logic [7:0]  w_drop_cnt;

  store_trace_buffer #(.SEQ_W(4)) u_wrap (
    .clk(clk), .reset(w_reset), .mem_write(w_wr), .data_adr(w_adr),
    .write_data(w_data), .out_valid(w_valid), .out_ready(w_rdy),
    .out_adr(w_out_adr), .out_data(w_out_data), .out_seq(w_out_seq), .count(w_count),
    .overflow(w_overflow), .drop_cnt(w_drop_cnt)
  );

`ifdef STORE_TRACE_FILTER_EN
  logic        f_reset, f_wr, f_rdy;
  logic [31:0] f_adr, f_data;
  logic        f_valid, f_overflow;
  logic [31:0] f_out_adr, f_out_data;
  logic [15:0] f_out_seq;
  logic [3:0]  f_count;
  logic [7:0]  f_drop_cnt;

  store_trace_buffer #(.FILT_BASE(32'h50), .FILT_MASK(32'hFFFF_FFF0)) u_filt (
    .clk(clk), .reset(f_reset), .mem_write(f_wr), .data_adr(f_adr),
    .write_data(f_data), .out_valid(f_valid), .out_ready(f_rdy),
    .out_adr(f_out_adr), .out_data(f_out_data), .out_seq(f_out_seq), .count(f_count),
    .overflow(f_overflow), .drop_cnt(f_drop_cnt)
  );
`endif

  typedef struct {
    logic        rst;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] data;
    logic        rdy;
    logic        ev;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [15:0] es;
    logic [3:0]  ec;
    logic        eo;
    logic [7:0]  edr;
  } vec_t;

  localparam int NVEC = 22;
  vec_t tbl [NVEC];

  int n_vec  = 0;
  int n_miss = 0;

  function automatic vec_t mk(logic rst, logic wr, logic [31:0] adr, logic [31:0] data,
                              logic rdy, logic ev, logic [31:0] ea, logic [31:0] ed,
                              logic [15:0] es, logic [3:0] ec, logic eo, logic [7:0] edr);
    vec_t v;
    v.rst = rst; v.wr = wr; v.adr = adr; v.data = data; v.rdy = rdy;
    v.ev = ev; v.ea = ea; v.ed = ed; v.es = es; v.ec = ec; v.eo = eo; v.edr = edr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic rd);
    reset = r; mem_write = w; data_adr = a; write_data = d; out_ready = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_write = 1'b0; data_adr = '0; write_data = '0; out_ready = 1'b0;
    w_reset = 1'b1; w_wr = 1'b0; w_adr = '0; w_data = '0; w_rdy = 1'b0;
`ifdef STORE_TRACE_FILTER_EN
    f_reset = 1'b1; f_wr = 1'b0; f_adr = '0; f_data = '0; f_rdy = 1'b0;
`endif

    // Table: reset, single store, fill past full, drain, next store
    tbl[0] = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(0, 1, 84, 28, 1, 1, 84, 28, 0, 1, 0, 0);
    tbl[2] = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    tbl[3] = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      if (k < 8) tbl[4+k] = mk(0, 1, 80, 32'(k), 0, 1, 80, 0, 0, 4'(k+1), 0, 0);
      else       tbl[4+k] = mk(0, 1, 80, 32'(k), 0, 1, 80, 0, 0, 4'd8, 1, 1);
    end
    for (int i = 0; i < 8; i++) begin
      tbl[13+i] = mk(0, 0, 0, 0, 1, (i < 7), 80, 32'(i+1), 16'(i+1), 4'(7-i), 1, 1);
    end
    tbl[21] = mk(0, 1, 80, 50, 0, 1, 80, 50, 9, 1, 1, 1);

    for (int v = 0; v < NVEC; v++) begin
      step(tbl[v].rst, tbl[v].wr, tbl[v].adr, tbl[v].data, tbl[v].rdy);
      if (v == 0) begin
        w_reset = 1'b0;
`ifdef STORE_TRACE_FILTER_EN
        f_reset = 1'b0;
`endif
      end
      chk("valid", v, 32'(out_valid), 32'(tbl[v].ev));
      chk("count", v, 32'(count), 32'(tbl[v].ec));
      chk("overflow", v, 32'(overflow), 32'(tbl[v].eo));
      chk("drop_cnt", v, 32'(drop_cnt), 32'(tbl[v].edr));
      if (tbl[v].ev) begin
        chk("out_adr", v, out_adr, tbl[v].ea);
        chk("out_data", v, out_data, tbl[v].ed);
        chk("out_seq", v, 32'(out_seq), 32'(tbl[v].es));
      end
    end

    // Push and pop together while full
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 1, 32'h100, 32'(10+k), 0);
    chk("full_count", 0, 32'(count), 32'd8);
    step(0, 1, 32'h100, 32'd99, 1);
    chk("pp_count", 0, 32'(count), 32'd8);
    chk("pp_drop", 0, 32'(drop_cnt), 32'd0);
    chk("pp_overflow", 0, 32'(overflow), 32'd0);
    for (int j = 0; j < 8; j++) begin
      chk("pp_data", j, out_data, (j < 7) ? 32'(11+j) : 32'd99);
      chk("pp_seq", j, 32'(out_seq), 32'(j+1));
      step(0, 0, 0, 0, 1);
    end
    chk("pp_empty", 0, 32'(count), 32'd0);

    // Reset with entries queued, overflow set and a store presented
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) step(0, 1, 32'h200, 32'(k), 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);
    chk("mid_count", 0, 32'(count), 32'd5);
    chk("mid_overflow", 0, 32'(overflow), 32'd1);
    step(1, 1, 32'h300, 32'd77, 0);
    chk("rst_valid", 0, 32'(out_valid), 32'd0);
    chk("rst_count", 0, 32'(count), 32'd0);
    chk("rst_overflow", 0, 32'(overflow), 32'd0);
    chk("rst_drop", 0, 32'(drop_cnt), 32'd0);
    step(0, 1, 32'h7, 32'h7, 0);
    chk("post_rst_seq", 0, 32'(out_seq), 32'd0);
    chk("post_rst_data", 0, out_data, 32'h7);
    chk("post_rst_count", 0, 32'(count), 32'd1);

    // Drop counter saturation
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 1, 32'h400, 32'(k), 0);
    for (int k = 0; k < 300; k++) step(0, 1, 32'h400, 32'hDEAD, 0);
    chk("sat_drop", 0, 32'(drop_cnt), 32'd255);
    chk("sat_overflow", 0, 32'(overflow), 32'd1);
    chk("sat_count", 0, 32'(count), 32'd8);
    chk("sat_head_seq", 0, 32'(out_seq), 32'd0);
    step(0, 0, 0, 0, 0);

    // Sequence wrap on the 4-bit instance
    for (int i = 0; i < 18; i++) begin
      w_wr = 1'b1; w_adr = 32'(i); w_data = 32'(i + 500); w_rdy = 1'b1;
      @(posedge clk);
      #1;
      chk("wrap_seq", i, 32'(w_out_seq), 32'(i % 16));
      chk("wrap_data", i, w_out_data, 32'(i + 500));
      chk("wrap_count", i, 32'(w_count), 32'd1);
      chk("wrap_valid", i, 32'(w_valid), 32'd1);
    end
    chk("wrap_adr", 0, w_out_adr, 32'd17);
    chk("wrap_drop", 0, 32'(w_drop_cnt), 32'd0);
    chk("wrap_overflow", 0, 32'(w_overflow), 32'd0);
    w_wr = 1'b0;

`ifdef STORE_TRACE_FILTER_EN
    f_wr = 1'b1; f_adr = 32'd84; f_data = 32'hA; f_rdy = 1'b0;
    @(posedge clk);
    #1;
    f_adr = 32'd100; f_data = 32'hB;
    @(posedge clk);
    #1;
    f_wr = 1'b0;
    chk("filt_count", 0, 32'(f_count), 32'd1);
    chk("filt_adr", 0, f_out_adr, 32'd84);
    chk("filt_data", 0, f_out_data, 32'hA);
    chk("filt_seq", 0, 32'(f_out_seq), 32'd0);
    chk("filt_valid", 0, 32'(f_valid), 32'd1);
    chk("filt_overflow", 0, 32'(f_overflow), 32'd0);
    chk("filt_drop", 0, 32'(f_drop_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
